bluetooth_send_ctrl: RTL

// - Transmit-side sequencer for the Bluetooth UART link. On a start pulse carrying a byte count,

---
 rtl/bluetooth_send_ctrl_pkg.sv | 47 ++++
 rtl/bluetooth_send_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bluetooth_send_ctrl_pkg.sv
// Shared definitions for the Bluetooth UART link controllers.
// Contents:
// - Data path and length width defaults, shared with bluetooth_receive_ctrl.
// - The 3-bit state encoding of the send sequencer, plus its enum type.
// - A helper that sizes the inter-byte gap counter.
package bluetooth_send_ctrl_pkg;

  localparam int BT_DATA_W = 8;
  localparam int BT_LEN_W  = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_READ      = 3'd1;
  localparam logic [2:0] ST_WAIT_DATA = 3'd2;
  localparam logic [2:0] ST_LOAD      = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;
  localparam logic [2:0] ST_FINISH    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_READ      = ST_READ,
    S_WAIT_DATA = ST_WAIT_DATA,
    S_LOAD      = ST_LOAD,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_GAP       = ST_GAP,
    S_FINISH    = ST_FINISH
  } send_state_e;

  // The gap counter must hold 0..gap_cycles. It is never narrower than
  // one bit, so that it stays a legal vector when the gap is disabled.
  function automatic int gap_cnt_width(input int gap_cycles);
    int w;
    w = 1;
    if (gap_cycles > 0) begin
      w = $clog2(gap_cycles + 1);
    end else begin
      w = 1;
    end
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/bluetooth_send_ctrl.sv
// bluetooth_send_ctrl: transmit-side sequencer for the Bluetooth UART link.
//
// A start pulse (tx_en) carries a byte count. The sequencer takes that many
// bytes out of the RX buffer FIFO and hands them to the UART TX core one at a
// time. It waits for each tx_done before it fetches the next byte, and it can
// insert an optional idle gap after each byte.
//
// Ports:
//   clk          in   system clock
//   reset_p      in   asynchronous reset, active-high
//   tx_en        in   start pulse; only looked at while idle
//   data_length  in   number of bytes to send, latched with tx_en
//   fifo_empty   in   FIFO empty flag
//   fifo_dout    in   FIFO read data, valid one cycle after rd_pulse
//   rd_pulse     out  one-cycle FIFO read strobe
//   send_data    out  byte presented to the UART TX core (held until the next load)
//   send_go      out  one-cycle start strobe to the UART TX core
//   tx_done      in   UART TX byte-complete pulse
//   busy         out  high from request acceptance until the done pulse
//   done         out  one-cycle pulse when the request completes
//
// All outputs come straight from flops.
module bluetooth_send_ctrl
  import bluetooth_send_ctrl_pkg::*;
#(
  parameter int DATA_W     = BT_DATA_W,
  parameter int LEN_W      = BT_LEN_W,
  parameter int GAP_CYCLES = 100
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              tx_en,
  input  logic [LEN_W-1:0]  data_length,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              rd_pulse,
  output logic [DATA_W-1:0] send_data,
  output logic              send_go,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  localparam int GAP_W = gap_cnt_width(GAP_CYCLES);
  // Terminal count of the gap counter. The GAP state counts 0..GAP_CYCLES-1,
  // which makes it last exactly GAP_CYCLES clocks.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  send_state_e       state_q,     state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [GAP_W-1:0]  gap_cnt_q,   gap_cnt_d;
  logic              rd_pulse_q,  rd_pulse_d;
  logic              send_go_q,   send_go_d;
  logic [DATA_W-1:0] send_data_q, send_data_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;

  // Next-state and next-output logic of the send sequencer
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_cnt_d   = gap_cnt_q;
    rd_pulse_d  = 1'b0;
    send_go_d   = 1'b0;
    send_data_d = send_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_en) begin
          remaining_d = data_length;
          busy_d      = 1'b1;
          if (data_length == {LEN_W{1'b0}}) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_READ: begin
        if (!fifo_empty) begin
          rd_pulse_d = 1'b1;
          state_d    = S_WAIT_DATA;
        end else begin
          state_d = S_READ;
        end
      end

      // The FIFO is not show-ahead. Its data appears one cycle after the strobe.
      S_WAIT_DATA: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        send_data_d = fifo_dout;
        send_go_d   = 1'b1;
        state_d     = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (tx_done) begin
          // remaining is at least 1 here. The guard keeps the counter from
          // wrapping, even if that were ever not the case.
          if (remaining_q != {LEN_W{1'b0}}) begin
            remaining_d = remaining_q - {{(LEN_W-1){1'b0}}, 1'b1};
          end else begin
            remaining_d = remaining_q;
          end
          if (remaining_q <= {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_d = S_FINISH;
          end else if (GAP_CYCLES == 0) begin
            state_d = S_READ;
          end else begin
            gap_cnt_d = {GAP_W{1'b0}};
            state_d   = S_GAP;
          end
        end else begin
          state_d = S_WAIT_DONE;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = {GAP_W{1'b0}};
          state_d   = S_READ;
        end else begin
          gap_cnt_d = gap_cnt_q + {{(GAP_W-1){1'b0}}, 1'b1};
          state_d   = S_GAP;
        end
      end

      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter and output registers; reset_p aborts any transfer at once
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q     <= S_IDLE;
      remaining_q <= {LEN_W{1'b0}};
      gap_cnt_q   <= {GAP_W{1'b0}};
      rd_pulse_q  <= 1'b0;
      send_go_q   <= 1'b0;
      send_data_q <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_cnt_q   <= gap_cnt_d;
      rd_pulse_q  <= rd_pulse_d;
      send_go_q   <= send_go_d;
      send_data_q <= send_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_pulse  = rd_pulse_q;
  assign send_go   = send_go_q;
  assign send_data = send_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
